// File: rtl/pwm_setpoint_ramp.sv
// Slews the PWM modulator setpoint toward a programmed target, one bounded step per
// modulator period, emitting each update with a write strobe wide enough for a 2-FF edge detector.
module pwm_setpoint_ramp #(
   parameter int MOD_WIDTH  = 8,
   parameter int STROBE_LEN = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 target_wr,
   input  logic [MOD_WIDTH-1:0] target,
   input  logic [MOD_WIDTH-1:0] step,
   input  logic                 period_tick,
   input  logic                 abort,
   output logic [MOD_WIDTH-1:0] mod_setpoint,
   output logic                 wr_mod_setpoint,
   output logic                 busy,
   output logic                 at_target
);

   localparam int CNT_W = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_LEN - 1);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_TICK = 2'd1;
   localparam logic [1:0] ST_WRITE     = 2'd2;
   localparam logic [1:0] ST_HOLD      = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [MOD_WIDTH-1:0] cur_q, cur_d;
   logic [MOD_WIDTH-1:0] tgt_q, tgt_d;
   logic [MOD_WIDTH-1:0] stp_q, stp_d;
   logic [MOD_WIDTH-1:0] set_q, set_d;
   logic                 wr_q, wr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 pend_q, pend_d;
   logic                 busy_q, busy_d;
   logic                 at_target_q, at_target_d;
   logic [2:0]           tick_sync_q, tick_sync_d;

   logic                 tick_edge;
   logic                 ramp_up;
   logic [MOD_WIDTH:0]   mag;
   logic [MOD_WIDTH-1:0] next_val;

   // [0],[1] synchronise the asynchronous strobe, [2] is the previous value for edge detect
   assign tick_sync_d = {tick_sync_q[1:0], period_tick};
   assign tick_edge   = tick_sync_q[1] & ~tick_sync_q[2];

   // Next value is computed against the target as it will stand after this cycle's
   // target_wr/abort, so a retarget landing with a tick is honoured immediately.
   always_comb begin
      ramp_up  = tgt_d > cur_q;
      mag      = ramp_up ? ({1'b0, tgt_d} - {1'b0, cur_q})
                         : ({1'b0, cur_q} - {1'b0, tgt_d});
      next_val = tgt_d;
      if (stp_d != '0 && mag > {1'b0, stp_d}) begin
         next_val = ramp_up ? (cur_q + stp_d) : (cur_q - stp_d);
      end
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      tgt_d   = tgt_q;
      stp_d   = stp_q;
      set_d   = set_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q | tick_edge;

      if (target_wr) begin
         tgt_d = target;
         stp_d = step;
      end else if (abort) begin
         tgt_d = cur_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (tgt_q != cur_q) state_d = ST_WAIT_TICK;
         end
         ST_WAIT_TICK: begin
            if (tgt_d == cur_q) begin
               state_d = ST_IDLE;
            end else if (pend_q) begin
               state_d = ST_WRITE;
               cur_d   = next_val;
               set_d   = next_val;
               wr_d    = 1'b1;
               cnt_d   = '0;
               pend_d  = tick_edge;
            end
         end
         ST_WRITE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_HOLD;
               wr_d    = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            // low phase guarantees the modulator sees a fresh rising edge next time
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = (tgt_d != cur_q) ? ST_WAIT_TICK : ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase

      busy_d      = (state_d != ST_IDLE) | (tgt_d != cur_d);
      at_target_d = ~busy_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cur_q       <= '0;
         tgt_q       <= '0;
         stp_q       <= '0;
         set_q       <= '0;
         wr_q        <= 1'b0;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         busy_q      <= 1'b0;
         at_target_q <= 1'b1;
         tick_sync_q <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         tgt_q       <= tgt_d;
         stp_q       <= stp_d;
         set_q       <= set_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         busy_q      <= busy_d;
         at_target_q <= at_target_d;
         tick_sync_q <= tick_sync_d;
      end
   end

   assign mod_setpoint    = set_q;
   assign wr_mod_setpoint = wr_q;
   assign busy            = busy_q;
   assign at_target       = at_target_q;

endmodule
